// File: rtl/code_lock_pkg.sv
// Shared types, default parameters and sizing helper for the code lock controller.
package code_lock_pkg;

    typedef enum logic [1:0] {
        ENTER    = 2'd0,
        UNLOCKED = 2'd1,
        FAIL     = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam int DEF_CODE_LEN       = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 8;
    localparam int DEF_LOCKOUT_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES = 32;

    // Bits needed to hold the value n (never less than one bit).
    function automatic int cnt_width(input int n);
        if (n < 2) return 1;
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/code_lock_fsm_cycle_timer.sv
// Loadable down-counter; saturates at zero and flags expiry while at zero.
module cycle_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         expired
);

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Code lock sequencer: walks the key index, accumulates symbol mismatches,
// counts failed attempts and times the unlock and lockout intervals.
// Optional inter-symbol timeout enabled by defining CODE_LOCK_TIMEOUT_EN.
//
//   state    | meaning
//   ENTER    | accepting symbols, key_idx_o selects the expected symbol
//   UNLOCKED | correct code entered, unlock_o held for UNLOCK_CYCLES
//   FAIL     | one-cycle error_o pulse after a failed attempt
//   LOCKOUT  | too many failures, lockout_o held for LOCKOUT_CYCLES
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sym_valid_i,
    input  logic                           match_i,
    input  logic                           clear_i,
    output logic [$clog2(CODE_LEN)-1:0]    key_idx_o,
    output logic                           unlock_o,
    output logic                           error_o,
    output logic                           lockout_o,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_o
);

    localparam int IDX_W   = $clog2(CODE_LEN);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int MAX_A   = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int TMR_W   = cnt_width(MAX_CYC);

    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(CODE_LEN - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX    = TRIES_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]   UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]   LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef CODE_LOCK_TIMEOUT_EN
    localparam logic [TMR_W-1:0]   TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    state_t               state;
    logic                 mismatch;
    logic                 sym_acc;
    logic                 last_sym;
    logic                 attempt_bad;
    logic                 attempt_ok;
    logic                 attempt_fail;
    logic                 timed_out;
    logic                 go_lock;
    logic [TRIES_W-1:0]   tries_next;
    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_load_val;
    logic [TMR_W-1:0]     tmr_value_unused;
    logic                 tmr_expired;

    // Attempt outcome decode and timer load selection for the coming edge.
    always_comb begin
        sym_acc      = (state == ENTER) && sym_valid_i && !clear_i;
        last_sym     = (key_idx_o == IDX_LAST);
        attempt_bad  = mismatch | ~match_i;
        attempt_ok   = sym_acc && last_sym && !attempt_bad;
`ifdef CODE_LOCK_TIMEOUT_EN
        timed_out    = (state == ENTER) && !sym_valid_i && !clear_i &&
                       (key_idx_o != '0) && tmr_expired;
`else
        timed_out    = 1'b0;
`endif
        attempt_fail = (sym_acc && last_sym && attempt_bad) || timed_out;
        tries_next   = tries_o + 1'b1;
        go_lock      = (tries_next == TRIES_MAX);
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (attempt_ok) begin
            tmr_load     = 1'b1;
            tmr_load_val = UNLOCK_LOAD;
        end else if (attempt_fail && go_lock) begin
            tmr_load     = 1'b1;
            tmr_load_val = LOCKOUT_LOAD;
        end
`ifdef CODE_LOCK_TIMEOUT_EN
        else if ((state == ENTER) && (sym_valid_i || clear_i)) begin
            tmr_load     = 1'b1;
            tmr_load_val = TIMEOUT_LOAD;
        end
`endif
    end

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .value    (tmr_value_unused),
        .expired  (tmr_expired)
    );

    // Main sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTER;
            key_idx_o <= '0;
            mismatch  <= 1'b0;
            tries_o   <= '0;
            unlock_o  <= 1'b0;
            error_o   <= 1'b0;
            lockout_o <= 1'b0;
        end else begin
            unique case (state)
                ENTER: begin
                    if (clear_i) begin
                        key_idx_o <= '0;
                        mismatch  <= 1'b0;
                    end else if (sym_acc && !last_sym) begin
                        key_idx_o <= key_idx_o + 1'b1;
                        mismatch  <= attempt_bad;
                    end else if (attempt_ok) begin
                        key_idx_o <= '0;
                        mismatch  <= 1'b0;
                        tries_o   <= '0;
                        unlock_o  <= 1'b1;
                        state     <= UNLOCKED;
                    end else if (attempt_fail) begin
                        key_idx_o <= '0;
                        mismatch  <= 1'b0;
                        tries_o   <= tries_next;
                        if (go_lock) begin
                            lockout_o <= 1'b1;
                            state     <= LOCKOUT;
                        end else begin
                            error_o <= 1'b1;
                            state   <= FAIL;
                        end
                    end
                end
                FAIL: begin
                    error_o <= 1'b0;
                    state   <= ENTER;
                end
                UNLOCKED: begin
                    if (tmr_expired) begin
                        unlock_o <= 1'b0;
                        state    <= ENTER;
                    end
                end
                LOCKOUT: begin
                    if (tmr_expired) begin
                        lockout_o <= 1'b0;
                        tries_o   <= '0;
                        state     <= ENTER;
                    end
                end
                default: state <= ENTER;
            endcase
        end
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: stimulus queues expected output events,
// a monitor measures each unlock/error/lockout pulse and checks it.
module tb_code_lock_fsm;

    localparam int K_UNLOCK  = 0;
    localparam int K_ERROR   = 1;
    localparam int K_LOCKOUT = 2;

    logic       clk;
    logic       rst_n;
    logic       sym_valid_i;
    logic       match_i;
    logic       clear_i;
    logic [1:0] key_idx_o;
    logic       unlock_o;
    logic       error_o;
    logic       lockout_o;
    logic [1:0] tries_o;

    code_lock_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sym_valid_i (sym_valid_i),
        .match_i     (match_i),
        .clear_i     (clear_i),
        .key_idx_o   (key_idx_o),
        .unlock_o    (unlock_o),
        .error_o     (error_o),
        .lockout_o   (lockout_o),
        .tries_o     (tries_o)
    );

    typedef struct {
        int kind;
        int start;
        int len;
        int tries_start;
        int tries_end;
    } ev_t;

    ev_t  evq[$];
    int   n_tests = 0;
    int   n_fails = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int start, input int len,
                           input int ts, input int te);
        ev_t e;
        e.kind = kind; e.start = start; e.len = len;
        e.tries_start = ts; e.tries_end = te;
        evq.push_back(e);
    endtask

    // Monitor: measures each output pulse and compares it to the queued expectation.
    initial begin
        logic [2:0] prev;
        logic [2:0] cur;
        int st[3];
        int stt[3];
        ev_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = '0;
                continue;
            end
            cur = {lockout_o, error_o, unlock_o};
            for (int k = 0; k < 3; k++) begin
                if (cur[k] && !prev[k]) begin
                    st[k]  = cyc;
                    stt[k] = int'(tries_o);
                end
                if (!cur[k] && prev[k]) begin
                    if (evq.size() == 0) begin
                        n_tests++;
                        n_fails++;
                        $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, st[k]);
                    end else begin
                        e = evq.pop_front();
                        check("ev_kind", k, e.kind);
                        check("ev_start", st[k], e.start);
                        check("ev_len", cyc - st[k], e.len);
                        check("ev_tries_start", stt[k], e.tries_start);
                        check("ev_tries_end", int'(tries_o), e.tries_end);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic drive(input logic v, input logic m, input logic c);
        sym_valid_i = v;
        match_i     = m;
        clear_i     = c;
        @(negedge clk);
        sym_valid_i = 1'b0;
        match_i     = 1'b0;
        clear_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Four symbols back-to-back; m[i] is the match result of symbol i.
    task automatic attempt(input logic [3:0] m, input logic chk_idx);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, m[i], 1'b0);
            if (chk_idx) check("key_idx_seq", int'(key_idx_o), (i + 1) % 4);
        end
    endtask

    initial begin
        sym_valid_i = 1'b0;
        match_i     = 1'b0;
        clear_i     = 1'b0;
        rst_n       = 1'b0;
        idle(2);
        check("rst_key_idx", int'(key_idx_o), 0);
        check("rst_unlock", int'(unlock_o), 0);
        check("rst_error", int'(error_o), 0);
        check("rst_lockout", int'(lockout_o), 0);
        check("rst_tries", int'(tries_o), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1);

        // Correct code: unlock for 8 cycles starting with the 4th symbol's edge.
        check("key_idx_start", int'(key_idx_o), 0);
        push_ev(K_UNLOCK, cyc + 4, 8, 0, 0);
        attempt(4'b1111, 1'b1);
        check("tries_after_ok", int'(tries_o), 0);
        idle(10);

        // Second symbol mismatches: single error pulse, tries 1.
        push_ev(K_ERROR, cyc + 4, 1, 1, 1);
        attempt(4'b1101, 1'b1);
        idle(2);
        check("tries_after_fail1", int'(tries_o), 1);
        check("key_idx_after_fail", int'(key_idx_o), 0);

        // Two more failures: second error, then lockout.
        push_ev(K_ERROR, cyc + 4, 1, 2, 2);
        attempt(4'b0111, 1'b0);
        idle(1);
        check("tries_after_fail2", int'(tries_o), 2);
        push_ev(K_LOCKOUT, cyc + 4, 16, 3, 0);
        attempt(4'b1110, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check("lockout_ignores_sym", int'(key_idx_o), 0);
        end
        idle(14);
        check("tries_after_lockout", int'(tries_o), 0);

        // Partial entry then clear: no error, index back to 0, mismatch forgotten.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("key_idx_before_clear", int'(key_idx_o), 2);
        drive(1'b0, 1'b0, 1'b1);
        check("key_idx_after_clear", int'(key_idx_o), 0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        check("key_idx_clear_with_sym", int'(key_idx_o), 0);
        check("tries_after_clear", int'(tries_o), 0);
        push_ev(K_UNLOCK, cyc + 4, 8, 0, 0);
        attempt(4'b1111, 1'b1);
        idle(10);

        // Reset in the middle of the unlock interval.
        mon_en = 1'b0;
        attempt(4'b1111, 1'b0);
        idle(3);
        check("unlock_before_reset", int'(unlock_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_unlock", int'(unlock_o), 0);
        check("async_rst_key_idx", int'(key_idx_o), 0);
        check("async_rst_tries", int'(tries_o), 0);
        check("async_rst_error", int'(error_o), 0);
        check("async_rst_lockout", int'(lockout_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        mon_en = 1'b1;

        // One symbol, then a long idle gap.
`ifdef CODE_LOCK_TIMEOUT_EN
        push_ev(K_ERROR, cyc + 33, 1, 1, 1);
`endif
        drive(1'b1, 1'b1, 1'b0);
        check("key_idx_partial", int'(key_idx_o), 1);
        idle(40);
`ifdef CODE_LOCK_TIMEOUT_EN
        check("timeout_key_idx", int'(key_idx_o), 0);
        check("timeout_tries", int'(tries_o), 1);
`else
        check("no_timeout_key_idx", int'(key_idx_o), 1);
        check("no_timeout_tries", int'(tries_o), 0);
`endif

        for (int i = 0; i < 50 && evq.size() != 0; i++) @(negedge clk);
        check("pending_events", evq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
